// File: rtl/div_pkg.sv
// Shared definitions for the sequential non-restoring divider.
//   DEF_WIDTH : default operand/quotient/remainder width
//   S_*       : controller state encodings
package div_pkg;

   localparam int DEF_WIDTH = 32;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_RUN     = 2'd1;
   localparam logic [1:0] S_CORRECT = 2'd2;
   localparam logic [1:0] S_FIN     = 2'd3;

endpackage

// File: rtl/nr_divider_seq_if.sv
// Start/done handshake between the ALU control FSM (master) and the divider (slave).
//   start, dividend, divisor              : master -> divider
//   busy, done, quotient, remainder,
//   div_by_zero                           : divider -> master
interface nr_divider_seq_if
   import div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);

   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );

endinterface

// File: rtl/nr_addsub.sv
// Combinational W-bit adder/subtractor.
//   a, b : operands
//   sub  : 0 -> s = a + b, 1 -> s = a - b (b inverted, sub used as carry-in)
//   s    : sum/difference, cout : carry out
module nr_addsub #(
   parameter int W = 33
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sub,
   output logic [W-1:0] s,
   output logic         cout
);

   logic [W-1:0] b_x;

   assign b_x       = b ^ {W{sub}};
   assign {cout, s} = {1'b0, a} + {1'b0, b_x} + {{W{1'b0}}, sub};

endmodule

// File: rtl/nr_divider_seq.sv
// Sequential unsigned non-restoring divider, one add/sub per cycle.
//   clk   : system clock, rising edge
//   rst_b : asynchronous active-low reset
//   bus   : slave side of the start/done handshake (operands in, results out)
// A divisor of 0 skips iteration: quotient = all ones, remainder = dividend.
module nr_divider_seq
   import div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = 6
) (
   input  logic              clk,
   input  logic              rst_b,
   nr_divider_seq_if.slave   bus
);

   logic [1:0]       state;
   logic [WIDTH:0]   a_reg;      // partial remainder, two's complement
   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] m_reg;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] quot_r;
   logic [WIDTH-1:0] rem_r;
   logic             dbz_r;

   logic [WIDTH:0]   a_shift;
   logic [WIDTH:0]   add_a;
   logic [WIDTH:0]   add_s;
   logic             add_sub;
   logic             unused_cout;

   // The single adder serves both the RUN iteration and the CORRECT restore add.
   always_comb begin
      a_shift = {a_reg[WIDTH-1:0], q_reg[WIDTH-1]};
      add_a   = a_shift;
      add_sub = ~a_reg[WIDTH];
      if (state == S_CORRECT) begin
         add_a   = a_reg;
         add_sub = 1'b0;
      end
   end

   nr_addsub #(.W(WIDTH + 1)) u_addsub (
      .a    (add_a),
      .b    ({1'b0, m_reg}),
      .sub  (add_sub),
      .s    (add_s),
      .cout (unused_cout)
   );

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state  <= S_IDLE;
         a_reg  <= '0;
         q_reg  <= '0;
         m_reg  <= '0;
         cnt    <= '0;
         quot_r <= '0;
         rem_r  <= '0;
         dbz_r  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  if (bus.divisor != '0) begin
                     a_reg <= '0;
                     q_reg <= bus.dividend;
                     m_reg <= bus.divisor;
                     cnt   <= CNT_W'(WIDTH);
                     dbz_r <= 1'b0;
                     state <= S_RUN;
                  end else begin
                     quot_r <= '1;
                     rem_r  <= bus.dividend;
                     dbz_r  <= 1'b1;
                     state  <= S_FIN;
                  end
               end
            end
            S_RUN: begin
               a_reg <= add_s;
               q_reg <= {q_reg[WIDTH-2:0], ~add_s[WIDTH]};
               cnt   <= cnt - 1'b1;
               if (cnt == CNT_W'(1)) state <= S_CORRECT;
            end
            S_CORRECT: begin
               quot_r <= q_reg;
               rem_r  <= a_reg[WIDTH] ? add_s[WIDTH-1:0] : a_reg[WIDTH-1:0];
               state  <= S_FIN;
            end
            default: state <= S_IDLE;   // S_FIN
         endcase
      end
   end

   assign bus.busy        = (state != S_IDLE);
   assign bus.done        = (state == S_FIN);
   assign bus.quotient    = quot_r;
   assign bus.remainder   = rem_r;
   assign bus.div_by_zero = dbz_r;

endmodule
